scr1_dmi_chain_ctrl: RTL and testbench
======================================

// Module: scr1_dmi_chain_ctrl
// PURPOSE
//  SysCLK-domain DTM scan-chain back end, directly downstream of the TAPC clock-domain synchronizer.
//  Consumes the synchronizer's qualified chain-select, ID, capture, shift, update and TDI outputs.
//  Implements the DTMCS and DMI-access data registers and drives a req/resp handshake to the Debug Module.
//  Returns the serial TDO bit to the synchronizer.
// PARAMETERS
//  CH_ID_W      2     chain-identifier width; ID 1 = DTMCS, ID 2 = DMI_ACCESS, other IDs ignored
//  ABITS        7     DMI address width
//  DATA_W       32    DMI data width
//  TIMEOUT_CYC  1024  request-abort limit in clk cycles (used only with SCR1_DMI_CHAIN_TIMEOUT_EN)
// PORTS
//  clk           in   1                system clock
//  tapc_trst_n   in   1                asynchronous active-low reset
//  ch_sel_i      in   1                DMI chain selected
//  ch_id_i       in   CH_ID_W          chain ID
//  ch_capture_i  in   1                capture strobe, 1 clk wide
//  ch_shift_i    in   1                shift strobe, 1 clk wide
//  ch_update_i   in   1                update strobe
//  ch_tdi_i      in   1                serial in, valid with ch_shift_i
//  ch_tdo_o      out  1                serial out
//  dmi_req_o     out  1                DM request
//  dmi_wr_o      out  1                1 = write, 0 = read
//  dmi_addr_o    out  ABITS            DM address
//  dmi_wdata_o   out  DATA_W           write data
//  dmi_resp_i    in   1                DM completion pulse, 1 clk
//  dmi_rdata_i   in   DATA_W           read data, valid with dmi_resp_i
// BEHAVIOUR
//  - Reset: all outputs 0; shift reg sr[ABITS+DATA_W+1:0] = 0; last_addr = 0, last_rdata = 0; sticky = 0; FSM IDLE.
//  - Strobes are acted on only when ch_sel_i = 1 and ch_id_i is 1 or 2; otherwise ignored.
//  - ch_tdo_o = sel ? sr[0] : 0, combinational from sr.
//  - Capture, ID 2: sr = {last_addr, last_rdata, op}; op = 3 if sticky or FSM != IDLE, else 0.
//    Capture while busy also sets sticky = 1.
//  - Capture, ID 1: sr[31:0] = DTMCS, upper bits 0.
//    DTMCS = {14'b0, 2'b0 (wr-only), 1'b0, idle = 3'd1, dmistat[1:0], abits = ABITS[5:0], version = 4'd1}.
//    dmistat is 3 if sticky, 2 if timeout flag set, else 0.
//  - Shift: sr[0] leaves and TDI enters the MSB of the active length (41 bits for ID 2, 32 for ID 1).
//    sr = {tdi, sr[L-1:1]}; one bit per strobe.
//  - Update, ID 2, decode sr = {addr, data, op}:
//      op 1/2 in IDLE with sticky = 0: FSM -> REQ.
//        Next cycle dmi_req_o = 1, dmi_wr_o = (op == 2), addr/wdata latched; last_addr = addr.
//      op 1/2 when busy: request dropped, sticky = 1.
//      op 0/3: no action.
//  - Update, ID 1: bit16 (dmireset) clears sticky and timeout flag.
//    bit17 (dmihardreset) additionally aborts REQ: dmi_req_o = 0 next cycle, FSM -> IDLE, late resp ignored.
//  - FSM IDLE -> REQ -> IDLE. In REQ, dmi_req_o and payload are held stable until dmi_resp_i.
//    On dmi_resp_i: FSM -> IDLE, req_o = 0 next cycle; last_rdata = dmi_rdata_i if read, unchanged if write.
//  - dmi_resp_i in IDLE is ignored.
//  - dmi_resp_i and ch_update_i in the same cycle: the update sees REQ (busy), so sticky = 1 and no new request.
//  - Capture/shift/update in the same cycle are not legal; priority is update > capture > shift.
//  - tapc_trst_n asserted mid-request: immediate async clear; dmi_req_o drops without waiting for resp.
// CONFIGURATION
//  SCR1_DMI_CHAIN_TIMEOUT_EN defined:
//    A counter runs in REQ; on reaching TIMEOUT_CYC with no resp, FSM -> IDLE and dmi_req_o = 0.
//    The timeout flag is set (dmistat = 2); the next ID-2 capture returns op = 2.
//    Counter is cleared on entry to REQ.
//  Undefined: no counter and no flag; REQ waits indefinitely; dmistat is never 2.
// TESTING
//  1. Reset release, no strobes -> ch_tdo_o = 0, dmi_req_o = 0, all outputs 0.
//  2. sel = 1, id = 1: capture + 32 shifts with ABITS = 7 -> serial out 0x0000_1071, LSB first.
//  3. id = 2: shift in addr 0x10, data 0x1, op 2, then update -> next clk req = 1, wr = 1, addr = 0x10, wdata = 0x1.
//     Resp pulse -> req = 0 next clk; capture -> op = 0.
//  4. Read addr 0x11, resp with rdata 0xDEADBEEF -> capture + shift out gives addr 0x11, data 0xDEADBEEF, op 0.
//  5. Update op = 1 while REQ pending -> no second req; capture op = 3; DTMCS dmistat = 3.
//     DTMCS update with bit16 = 1 -> dmistat = 0.
//  6. With macro, TIMEOUT_CYC = 8, DM never responds -> req drops after 8 clks; capture op = 2; dmistat = 2.
//     Without macro -> req still high after 100 clks.

Source files
------------

// File: rtl/scr1_dmi_chain_ctrl.sv
// DTM scan-chain back end in the clk domain: DTMCS / DMI-access data registers plus the DM req/resp handshake.
// Optional request timeout is enabled by defining SCR1_DMI_CHAIN_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no DM transaction outstanding
// ST_REQ  | dmi_req_o held high with a stable payload until dmi_resp_i
module scr1_dmi_chain_ctrl #(
   parameter int CH_ID_W     = 2,
   parameter int ABITS       = 7,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                tapc_trst_n,
   input  logic                ch_sel_i,
   input  logic [CH_ID_W-1:0]  ch_id_i,
   input  logic                ch_capture_i,
   input  logic                ch_shift_i,
   input  logic                ch_update_i,
   input  logic                ch_tdi_i,
   output logic                ch_tdo_o,
   output logic                dmi_req_o,
   output logic                dmi_wr_o,
   output logic [ABITS-1:0]    dmi_addr_o,
   output logic [DATA_W-1:0]   dmi_wdata_o,
   input  logic                dmi_resp_i,
   input  logic [DATA_W-1:0]   dmi_rdata_i
);

   localparam int SR_W = ABITS + DATA_W + 2;

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t              state;
   logic [SR_W-1:0]     sr;
   logic [ABITS-1:0]    last_addr;
   logic [DATA_W-1:0]   last_rdata;
   logic                sticky;
   logic                to_flag;

`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0]    to_cnt;
`else
   assign to_flag = 1'b0;
`endif

   logic                id_dtmcs;
   logic                id_dmi;
   logic                ch_act;
   logic                busy;
   logic [1:0]          dmistat;
   logic [1:0]          cap_op;
   logic [31:0]         dtmcs;
   logic [1:0]          upd_op;
   logic [DATA_W-1:0]   upd_data;
   logic [ABITS-1:0]    upd_addr;

   assign id_dtmcs = (ch_id_i == CH_ID_W'(1));
   assign id_dmi   = (ch_id_i == CH_ID_W'(2));
   assign ch_act   = ch_sel_i & (id_dtmcs | id_dmi);
   assign busy     = (state == ST_REQ);
   assign ch_tdo_o = ch_sel_i ? sr[0] : 1'b0;

   assign dmistat = sticky ? 2'd3 : (to_flag ? 2'd2 : 2'd0);
   assign cap_op  = (sticky | busy) ? 2'd3 : (to_flag ? 2'd2 : 2'd0);
   assign dtmcs   = {14'b0, 2'b0, 1'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};

   assign upd_op   = sr[1:0];
   assign upd_data = sr[DATA_W+1:2];
   assign upd_addr = sr[SR_W-1:DATA_W+2];

   always_ff @(posedge clk or negedge tapc_trst_n) begin
      if (!tapc_trst_n) begin
         state       <= ST_IDLE;
         sr          <= '0;
         last_addr   <= '0;
         last_rdata  <= '0;
         sticky      <= 1'b0;
         dmi_req_o   <= 1'b0;
         dmi_wr_o    <= 1'b0;
         dmi_addr_o  <= '0;
         dmi_wdata_o <= '0;
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
         to_flag     <= 1'b0;
         to_cnt      <= '0;
`endif
      end else begin
         // DM side first; a same-cycle update still observes the pre-response busy state
         if (busy && dmi_resp_i) begin
            state     <= ST_IDLE;
            dmi_req_o <= 1'b0;
            if (!dmi_wr_o)
               last_rdata <= dmi_rdata_i;
         end
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
         else if (busy) begin
            if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               state     <= ST_IDLE;
               dmi_req_o <= 1'b0;
               to_flag   <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
`endif

         if (ch_act && ch_update_i) begin
            if (id_dmi) begin
               if (upd_op == 2'd1 || upd_op == 2'd2) begin
                  if (busy) begin
                     sticky <= 1'b1;
                  end else if (!sticky) begin
                     state       <= ST_REQ;
                     dmi_req_o   <= 1'b1;
                     dmi_wr_o    <= (upd_op == 2'd2);
                     dmi_addr_o  <= upd_addr;
                     dmi_wdata_o <= upd_data;
                     last_addr   <= upd_addr;
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
                     to_cnt      <= '0;
`endif
                  end
               end
            end else begin
               if (sr[16] || sr[17]) begin
                  sticky <= 1'b0;
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
                  to_flag <= 1'b0;
`endif
               end
               // hard reset abandons the transaction; a late response then lands in IDLE and is dropped
               if (sr[17] && busy) begin
                  state     <= ST_IDLE;
                  dmi_req_o <= 1'b0;
               end
            end
         end else if (ch_act && ch_capture_i) begin
            if (id_dmi) begin
               sr <= {last_addr, last_rdata, cap_op};
               if (busy)
                  sticky <= 1'b1;
            end else begin
               sr <= SR_W'(dtmcs);
            end
         end else if (ch_act && ch_shift_i) begin
            if (id_dmi)
               sr <= {ch_tdi_i, sr[SR_W-1:1]};
            else
               sr[31:0] <= {ch_tdi_i, sr[31:1]};
         end
      end
   end

endmodule

// File: tb/tb_scr1_dmi_chain_ctrl.sv
// Directed bench for scr1_dmi_chain_ctrl: DTMCS readout, DMI write/read, sticky busy, dmireset/hardreset, timeout.
// Build with SCR1_DMI_CHAIN_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYC = 8).
module tb_scr1_dmi_chain_ctrl;

   localparam int ABITS  = 7;
   localparam int DATA_W = 32;
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
   localparam int TO_CYC = 8;
`else
   localparam int TO_CYC = 1024;
`endif

   logic              clk = 1'b0;
   logic              tapc_trst_n = 1'b0;
   logic              ch_sel_i = 1'b0;
   logic [1:0]        ch_id_i = '0;
   logic              ch_capture_i = 1'b0;
   logic              ch_shift_i = 1'b0;
   logic              ch_update_i = 1'b0;
   logic              ch_tdi_i = 1'b0;
   logic              ch_tdo_o;
   logic              dmi_req_o;
   logic              dmi_wr_o;
   logic [ABITS-1:0]  dmi_addr_o;
   logic [DATA_W-1:0] dmi_wdata_o;
   logic              dmi_resp_i = 1'b0;
   logic [DATA_W-1:0] dmi_rdata_i = '0;

   int checks = 0;
   int errors = 0;
   logic [40:0] d;
   logic [31:0] exp_rdata;

   always #5 clk = ~clk;

   scr1_dmi_chain_ctrl #(
      .CH_ID_W(2), .ABITS(ABITS), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .tapc_trst_n(tapc_trst_n),
      .ch_sel_i(ch_sel_i), .ch_id_i(ch_id_i),
      .ch_capture_i(ch_capture_i), .ch_shift_i(ch_shift_i), .ch_update_i(ch_update_i),
      .ch_tdi_i(ch_tdi_i), .ch_tdo_o(ch_tdo_o),
      .dmi_req_o(dmi_req_o), .dmi_wr_o(dmi_wr_o), .dmi_addr_o(dmi_addr_o),
      .dmi_wdata_o(dmi_wdata_o), .dmi_resp_i(dmi_resp_i), .dmi_rdata_i(dmi_rdata_i)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [40:0] dmi_word(input logic [6:0] a, input logic [31:0] dt, input logic [1:0] op);
      return {a, dt, op};
   endfunction

   // all tasks start and end just after a falling edge
   task automatic capture(input logic [1:0] id);
      ch_sel_i = 1'b1; ch_id_i = id; ch_capture_i = 1'b1;
      @(negedge clk);
      ch_capture_i = 1'b0;
   endtask

   task automatic shift(input logic [1:0] id, input int len, input logic [40:0] din, output logic [40:0] dout);
      dout = '0;
      ch_sel_i = 1'b1; ch_id_i = id;
      for (int i = 0; i < len; i++) begin
         dout[i] = ch_tdo_o;
         ch_shift_i = 1'b1; ch_tdi_i = din[i];
         @(negedge clk);
      end
      ch_shift_i = 1'b0; ch_tdi_i = 1'b0;
   endtask

   task automatic update(input logic [1:0] id);
      ch_sel_i = 1'b1; ch_id_i = id; ch_update_i = 1'b1;
      @(negedge clk);
      ch_update_i = 1'b0;
   endtask

   task automatic resp(input logic [31:0] rd);
      dmi_resp_i = 1'b1; dmi_rdata_i = rd;
      @(negedge clk);
      dmi_resp_i = 1'b0; dmi_rdata_i = '0;
   endtask

   initial begin
      #23 tapc_trst_n = 1'b1;
      @(negedge clk);
      chk("rst_tdo", ch_tdo_o, 0);
      chk("rst_req", dmi_req_o, 0);
      chk("rst_wr", dmi_wr_o, 0);
      chk("rst_addr", dmi_addr_o, 0);
      chk("rst_wdata", dmi_wdata_o, 0);

      capture(2'd1);
      shift(2'd1, 32, '0, d);
      chk("dtmcs_idle", d[31:0], 32'h0000_1071);

      // write 0x1 to 0x10
      capture(2'd2);
      shift(2'd2, 41, dmi_word(7'h10, 32'h1, 2'd2), d);
      chk("cap_reset_word", d, 0);
      update(2'd2);
      chk("wr_req", dmi_req_o, 1);
      chk("wr_wr", dmi_wr_o, 1);
      chk("wr_addr", dmi_addr_o, 7'h10);
      chk("wr_wdata", dmi_wdata_o, 32'h1);
      repeat (3) @(negedge clk);
      chk("wr_req_hold", dmi_req_o, 1);
      resp(32'h0);
      chk("wr_req_drop", dmi_req_o, 0);

      // read 0x11
      capture(2'd2);
      shift(2'd2, 41, dmi_word(7'h11, 32'h0, 2'd1), d);
      chk("cap_after_wr", d, dmi_word(7'h10, 32'h0, 2'd0));
      update(2'd2);
      chk("rd_req", dmi_req_o, 1);
      chk("rd_wr", dmi_wr_o, 0);
      chk("rd_addr", dmi_addr_o, 7'h11);
      resp(32'hDEAD_BEEF);
      chk("rd_req_drop", dmi_req_o, 0);
      capture(2'd2);
      shift(2'd2, 41, dmi_word(7'h12, 32'h0, 2'd1), d);
      chk("cap_after_rd", d, dmi_word(7'h11, 32'hDEAD_BEEF, 2'd0));
      exp_rdata = 32'hDEAD_BEEF;

`ifndef SCR1_DMI_CHAIN_TIMEOUT_EN
      // second request while busy
      update(2'd2);
      chk("busy_req", dmi_req_o, 1);
      shift(2'd2, 41, dmi_word(7'h13, 32'h0, 2'd1), d);
      update(2'd2);
      chk("busy_no_new_addr", dmi_addr_o, 7'h12);
      chk("busy_req_still", dmi_req_o, 1);
      capture(2'd2);
      shift(2'd2, 41, '0, d);
      chk("cap_busy_op3", d, dmi_word(7'h12, 32'hDEAD_BEEF, 2'd3));
      capture(2'd1);
      shift(2'd1, 32, 41'h1_0000, d);
      chk("dtmcs_sticky", d[31:0], 32'h0000_1C71);
      update(2'd1);
      capture(2'd1);
      shift(2'd1, 32, '0, d);
      chk("dtmcs_cleared", d[31:0], 32'h0000_1071);
      resp(32'hCAFE_F00D);
      chk("busy_req_drop", dmi_req_o, 0);

      // response while idle must not touch last_rdata
      resp(32'h1234_5678);
      capture(2'd2);
      shift(2'd2, 41, dmi_word(7'h14, 32'h0, 2'd1), d);
      chk("idle_resp_ignored", d, dmi_word(7'h12, 32'hCAFE_F00D, 2'd0));

      // update and response in the same cycle
      update(2'd2);
      shift(2'd2, 41, dmi_word(7'h15, 32'h0, 2'd2), d);
      ch_update_i = 1'b1; dmi_resp_i = 1'b1; dmi_rdata_i = 32'h0BAD_F00D;
      @(negedge clk);
      ch_update_i = 1'b0; dmi_resp_i = 1'b0; dmi_rdata_i = '0;
      chk("coll_req", dmi_req_o, 0);
      chk("coll_addr", dmi_addr_o, 7'h14);
      capture(2'd1);
      shift(2'd1, 32, 41'h1_0000, d);
      chk("coll_sticky", d[31:0], 32'h0000_1C71);
      update(2'd1);

      // dmihardreset aborts pending read; late response dropped
      capture(2'd2);
      shift(2'd2, 41, dmi_word(7'h16, 32'h0, 2'd1), d);
      chk("cap_after_coll", d, dmi_word(7'h14, 32'h0BAD_F00D, 2'd0));
      update(2'd2);
      chk("hr_req", dmi_req_o, 1);
      capture(2'd1);
      shift(2'd1, 32, 41'h2_0000, d);
      chk("hr_dtmcs", d[31:0], 32'h0000_1071);
      update(2'd1);
      chk("hr_req_drop", dmi_req_o, 0);
      resp(32'h7777_7777);
      capture(2'd2);
      shift(2'd2, 41, '0, d);
      chk("hr_late_resp", d, dmi_word(7'h16, 32'h0BAD_F00D, 2'd0));
      exp_rdata = 32'h0BAD_F00D;
`endif

      // DM never responds
      shift(2'd2, 41, dmi_word(7'h17, 32'h0, 2'd1), d);
      update(2'd2);
      chk("nr_req", dmi_req_o, 1);
`ifdef SCR1_DMI_CHAIN_TIMEOUT_EN
      repeat (7) @(negedge clk);
      chk("to_req_hold", dmi_req_o, 1);
      @(negedge clk);
      chk("to_req_drop", dmi_req_o, 0);
      capture(2'd2);
      shift(2'd2, 41, '0, d);
      chk("to_cap_op2", d, dmi_word(7'h17, exp_rdata, 2'd2));
      capture(2'd1);
      shift(2'd1, 32, 41'h1_0000, d);
      chk("to_dtmcs", d[31:0], 32'h0000_1871);
      update(2'd1);
      capture(2'd1);
      shift(2'd1, 32, '0, d);
      chk("to_dtmcs_clr", d[31:0], 32'h0000_1071);
      shift(2'd2, 41, dmi_word(7'h18, 32'h0, 2'd1), d);
      update(2'd2);
      chk("to_req2", dmi_req_o, 1);
`else
      repeat (100) @(negedge clk);
      chk("nr_req_100", dmi_req_o, 1);
`endif

      // async reset mid-request
      #2 tapc_trst_n = 1'b0;
      #1;
      chk("arst_req", dmi_req_o, 0);
      chk("arst_addr", dmi_addr_o, 0);
      @(negedge clk);
      tapc_trst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
